// File: rtl/vram_if0_arb_pkg.sv
// Shared definitions for the VRAM interface-0 arbiter: default bus widths and
// the arbiter state encoding.
package vram_if0_arb_pkg;

  localparam int unsigned VRAM_IF0_ADDR_W = 15;
  localparam int unsigned VRAM_IF0_DATA_W = 32;
  localparam int unsigned BYTESEL_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vram_if0_arb.sv
// Two-requester arbiter for VRAM interface 0.
// Grants one requester at a time (fixed priority to r0 or round-robin), holds
// the winner's access on the if0_* port until the VRAM acknowledges, then
// returns a one-cycle rN_ack with captured read data.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   cfg_r0_prio          1 = r0 always wins a tie, 0 = round-robin
//   rN_req/addr/wrdata/wrbytesel/write   requester N access (N=0,1)
//   rN_ack, rN_rddata    completion pulse and held read data
//   if0_*                registered access toward the VRAM port
//   if0_ack, if0_rddata  VRAM completion and read data
//   arb_busy             high whenever the arbiter is not idle
module vram_if0_arb
  import vram_if0_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_IF0_ADDR_W,
  parameter int unsigned DATA_W = VRAM_IF0_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_r0_prio,

  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wrdata,
  input  logic [3:0]        r0_wrbytesel,
  input  logic              r0_write,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rddata,

  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wrdata,
  input  logic [3:0]        r1_wrbytesel,
  input  logic              r1_write,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rddata,

  output logic [ADDR_W-1:0] if0_addr,
  output logic [DATA_W-1:0] if0_wrdata,
  output logic [3:0]        if0_wrbytesel,
  output logic              if0_write,
  output logic              if0_strobe,
  input  logic              if0_ack,
  input  logic [DATA_W-1:0] if0_rddata,

  output logic              arb_busy
);

  // Winner select: 0 = requester 0, 1 = requester 1. On a tie in round-robin
  // mode the requester that did not win last time is chosen.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic prio0, input logic last);
    logic win;
    win = 1'b0;
    if (req0 && req1) begin
      win = prio0 ? 1'b0 : ~last;
    end else if (req1) begin
      win = 1'b1;
    end
    return win;
  endfunction

  arb_state_e state_q, state_d;

  // last_grant_q also identifies the requester owning the access in WAIT,
  // since it is updated on every grant.
  logic              last_grant_q, last_grant_d;
  logic              win_c;
  logic              any_req_c;

  logic [ADDR_W-1:0] if0_addr_d;
  logic [DATA_W-1:0] if0_wrdata_d;
  logic [3:0]        if0_wrbytesel_d;
  logic              if0_write_d;
  logic              if0_strobe_d;
  logic              r0_ack_d, r1_ack_d;
  logic [DATA_W-1:0] r0_rddata_d, r1_rddata_d;
  logic              arb_busy_d;

  assign any_req_c = r0_req | r1_req;
  assign win_c     = pick_winner(r0_req, r1_req, cfg_r0_prio, last_grant_q);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      if0_addr      <= '0;
      if0_wrdata    <= '0;
      if0_wrbytesel <= '0;
      if0_write     <= 1'b0;
      if0_strobe    <= 1'b0;
      r0_ack        <= 1'b0;
      r1_ack        <= 1'b0;
      r0_rddata     <= '0;
      r1_rddata     <= '0;
      arb_busy      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      if0_addr      <= if0_addr_d;
      if0_wrdata    <= if0_wrdata_d;
      if0_wrbytesel <= if0_wrbytesel_d;
      if0_write     <= if0_write_d;
      if0_strobe    <= if0_strobe_d;
      r0_ack        <= r0_ack_d;
      r1_ack        <= r1_ack_d;
      r0_rddata     <= r0_rddata_d;
      r1_rddata     <= r1_rddata_d;
      arb_busy      <= arb_busy_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req_c) state_d = ST_WAIT;
      ST_WAIT: if (if0_ack)   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    last_grant_d    = last_grant_q;
    if0_addr_d      = if0_addr;
    if0_wrdata_d    = if0_wrdata;
    if0_wrbytesel_d = if0_wrbytesel;
    if0_write_d     = if0_write;
    if0_strobe_d    = if0_strobe;
    r0_ack_d        = 1'b0;
    r1_ack_d        = 1'b0;
    r0_rddata_d     = r0_rddata;
    r1_rddata_d     = r1_rddata;
    arb_busy_d      = (state_d != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          last_grant_d = win_c;
          if0_strobe_d = 1'b1;
          if (win_c) begin
            if0_addr_d      = r1_addr;
            if0_wrdata_d    = r1_wrdata;
            if0_wrbytesel_d = r1_wrbytesel;
            if0_write_d     = r1_write;
          end else begin
            if0_addr_d      = r0_addr;
            if0_wrdata_d    = r0_wrdata;
            if0_wrbytesel_d = r0_wrbytesel;
            if0_write_d     = r0_write;
          end
        end
      end
      ST_WAIT: begin
        // Read data is captured only for reads; writes keep the old value.
        if (if0_ack) begin
          if0_strobe_d = 1'b0;
          if (last_grant_q) begin
            r1_ack_d = 1'b1;
            if (!if0_write) r1_rddata_d = if0_rddata;
          end else begin
            r0_ack_d = 1'b1;
            if (!if0_write) r0_rddata_d = if0_rddata;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vram_if0_arb.sv
// Testbench for vram_if0_arb: behavioural 4-slot VRAM model plus directed
// and randomized requester traffic checked against a transaction-level
// reference (shadow memory, expected winner, held read data).
`timescale 1ns/1ps
module tb_vram_if0_arb;
  import vram_if0_arb_pkg::*;

  localparam int unsigned AW = VRAM_IF0_ADDR_W;
  localparam int unsigned DW = VRAM_IF0_DATA_W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cfg_r0_prio;
  logic          r0_req, r1_req;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wrdata, r1_wrdata;
  logic [3:0]    r0_wrbytesel, r1_wrbytesel;
  logic          r0_write, r1_write;
  logic          r0_ack, r1_ack;
  logic [DW-1:0] r0_rddata, r1_rddata;
  logic [AW-1:0] if0_addr;
  logic [DW-1:0] if0_wrdata;
  logic [3:0]    if0_wrbytesel;
  logic          if0_write;
  logic          if0_strobe;
  logic          if0_ack = 1'b0;
  logic [DW-1:0] if0_rddata = '0;
  logic          arb_busy;

  always #5 clk = ~clk;

  vram_if0_arb dut (
    .clk(clk), .reset_n(reset_n), .cfg_r0_prio(cfg_r0_prio),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_wrdata(r0_wrdata),
    .r0_wrbytesel(r0_wrbytesel), .r0_write(r0_write),
    .r0_ack(r0_ack), .r0_rddata(r0_rddata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_wrdata(r1_wrdata),
    .r1_wrbytesel(r1_wrbytesel), .r1_write(r1_write),
    .r1_ack(r1_ack), .r1_rddata(r1_rddata),
    .if0_addr(if0_addr), .if0_wrdata(if0_wrdata),
    .if0_wrbytesel(if0_wrbytesel), .if0_write(if0_write),
    .if0_strobe(if0_strobe), .if0_ack(if0_ack), .if0_rddata(if0_rddata),
    .arb_busy(arb_busy)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [3:0] sel);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // VRAM model: the port owns slot 0 of a free-running 4-slot rotation; a
  // write commits in the slot cycle and the ack follows one cycle later.
  logic [1:0]    slot = 2'd0;
  logic [DW-1:0] vmem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) vmem[i] = '0;

  always @(posedge clk) begin
    slot    <= slot + 2'd1;
    if0_ack <= 1'b0;
    if (if0_strobe === 1'b1 && slot == 2'd0) begin
      if0_ack    <= 1'b1;
      if0_rddata <= vmem[if0_addr];
      if (if0_write) vmem[if0_addr] <= merge(vmem[if0_addr], if0_wrdata, if0_wrbytesel);
    end
  end

  // Reference state.
  int            n_vec = 0;
  int            n_err = 0;
  int            last_g = 1;
  logic [DW-1:0] shadow [int];
  logic [AW-1:0] iss_addr [2];
  logic [DW-1:0] iss_data [2];
  logic [3:0]    iss_sel  [2];
  logic          iss_wr   [2];
  logic [DW-1:0] exp_rd   [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
  endfunction

  function automatic int exp_winner(input bit p0, input bit p1, input bit cfg);
    if (p0 && p1) return cfg ? 0 : 1 - last_g;
    return p0 ? 0 : 1;
  endfunction

  task automatic set_req(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] s, input logic w);
    iss_addr[n] = a; iss_data[n] = d; iss_sel[n] = s; iss_wr[n] = w;
    if (n == 0) begin
      r0_addr = a; r0_wrdata = d; r0_wrbytesel = s; r0_write = w; r0_req = 1'b1;
    end else begin
      r1_addr = a; r1_wrdata = d; r1_wrbytesel = s; r1_write = w; r1_req = 1'b1;
    end
  endtask

  task automatic drop_req(input int n);
    if (n == 0) r0_req = 1'b0; else r1_req = 1'b0;
  endtask

  task automatic wait_ack(output int who, output int cyc);
    who = -1;
    cyc = 0;
    while (who < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (r0_ack === 1'b1) who = 0;
      else if (r1_ack === 1'b1) who = 1;
    end
    if (who < 0) chk("ack_timeout", 64'(who >= 0), 64'(1));
  endtask

  // Completion of requester n's issued access: update reference memory or
  // expected read data, then compare the held read data.
  task automatic on_ack(input int n);
    if (iss_wr[n]) shadow[int'(iss_addr[n])] = merge(sh_rd(iss_addr[n]), iss_data[n], iss_sel[n]);
    else exp_rd[n] = sh_rd(iss_addr[n]);
    chk(n == 0 ? "r0_rddata" : "r1_rddata", 64'(n == 0 ? r0_rddata : r1_rddata), 64'(exp_rd[n]));
    last_g = n;
  endtask

  // Protocol monitor: never two acks together, acks are single-cycle pulses.
  logic prev0 = 1'b0, prev1 = 1'b0;
  always @(negedge clk) begin
    if (r0_ack === 1'b1 || r1_ack === 1'b1) chk("one_ack", 64'(r0_ack & r1_ack), 64'(0));
    if (r0_ack === 1'b1) chk("r0_ack_pulse", 64'(prev0), 64'(0));
    if (r1_ack === 1'b1) chk("r1_ack_pulse", 64'(prev1), 64'(0));
    prev0 = (r0_ack === 1'b1);
    prev1 = (r1_ack === 1'b1);
  end

  initial begin
    int  who, cyc, e, m;
    bit  seen, p0, p1, pair;

    reset_n = 1'b0; cfg_r0_prio = 1'b0;
    r0_req = 1'b0; r0_addr = '0; r0_wrdata = '0; r0_wrbytesel = '0; r0_write = 1'b0;
    r1_req = 1'b0; r1_addr = '0; r1_wrdata = '0; r1_wrbytesel = '0; r1_write = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_strobe", 64'(if0_strobe), 64'(0));
    chk("rst_addr", 64'(if0_addr), 64'(0));
    chk("rst_wrdata", 64'(if0_wrdata), 64'(0));
    chk("rst_bytesel", 64'(if0_wrbytesel), 64'(0));
    chk("rst_write", 64'(if0_write), 64'(0));
    chk("rst_r0_ack", 64'(r0_ack), 64'(0));
    chk("rst_r1_ack", 64'(r1_ack), 64'(0));
    chk("rst_r0_rddata", 64'(r0_rddata), 64'(0));
    chk("rst_r1_rddata", 64'(r1_rddata), 64'(0));
    chk("rst_busy", 64'(arb_busy), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(arb_busy), 64'(0));

    // r0 write; fields must hold while waiting even if the requester changes them.
    set_req(0, AW'(32'h0010), 32'hDEADBEEF, 4'hF, 1'b1);
    seen = 0; cyc = 0; who = -1;
    while (who < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (r0_ack === 1'b1) who = 0;
      else if (r1_ack === 1'b1) who = 1;
      else if (if0_strobe === 1'b1) begin
        chk("wr_if0_write", 64'(if0_write), 64'(1));
        chk("wr_if0_addr", 64'(if0_addr), 64'(32'h0010));
        chk("wr_if0_wrdata", 64'(if0_wrdata), 64'(32'hDEADBEEF));
        chk("wr_busy", 64'(arb_busy), 64'(1));
        if (!seen) begin
          r0_addr = AW'(32'h7777); r0_wrdata = 32'h0BADF00D; r0_write = 1'b0;
        end
        seen = 1;
      end else if (seen) chk("wr_strobe_held", 64'(if0_strobe), 64'(1));
    end
    chk("wr_who", 64'(who), 64'(0));
    chk("wr_latency_ok", 64'(cyc >= 3 && cyc <= 6), 64'(1));
    chk("wr_strobe_clr", 64'(if0_strobe), 64'(0));
    on_ack(0);
    drop_req(0);
    @(negedge clk);
    chk("wr_ram", 64'(vmem[16]), 64'(32'hDEADBEEF));
    chk("wr_ack_low", 64'(r0_ack), 64'(0));

    // r1 read of the same word; data held after the request drops.
    set_req(1, AW'(32'h0010), '0, 4'h0, 1'b0);
    wait_ack(who, cyc);
    chk("rd_who", 64'(who), 64'(1));
    chk("rd_latency_ok", 64'(cyc >= 3 && cyc <= 6), 64'(1));
    if (who == 1) on_ack(1);
    drop_req(1);
    repeat (3) @(negedge clk);
    chk("rd_held", 64'(r1_rddata), 64'(32'hDEADBEEF));

    // Round-robin with both requesting continuously.
    cfg_r0_prio = 1'b0;
    set_req(0, AW'(32'h0010), '0, 4'h0, 1'b0);
    set_req(1, AW'(32'h0011), 32'h01020304, 4'h5, 1'b1);
    for (int k = 0; k < 6; k++) begin
      e = exp_winner(1, 1, cfg_r0_prio);
      wait_ack(who, cyc);
      chk("rr_order", 64'(who), 64'(e));
      if (who < 0) break;
      on_ack(who);
    end
    drop_req(0); drop_req(1);
    repeat (2) @(negedge clk);

    // Fixed priority: r0 wins every tie, r1 only after r0 drops.
    cfg_r0_prio = 1'b1;
    set_req(0, AW'(32'h0011), '0, 4'h0, 1'b0);
    set_req(1, AW'(32'h0012), 32'hCAFEF00D, 4'hF, 1'b1);
    for (int k = 0; k < 6; k++) begin
      wait_ack(who, cyc);
      chk("prio_r0", 64'(who), 64'(0));
      if (who < 0) break;
      on_ack(who);
    end
    drop_req(0);
    wait_ack(who, cyc);
    chk("prio_r1_after", 64'(who), 64'(1));
    if (who == 1) on_ack(1);
    drop_req(1);
    repeat (2) @(negedge clk);

    // Reset right after strobe rises; the late VRAM ack must be ignored and
    // the committed write stays in memory.
    cfg_r0_prio = 1'b0;
    for (int k = 0; k < 4 && slot != 2'd3; k++) @(negedge clk);
    set_req(0, AW'(32'h0030), 32'h12345678, 4'hF, 1'b1);
    @(negedge clk);
    chk("abort_strobe_up", 64'(if0_strobe), 64'(1));
    reset_n = 1'b0;
    drop_req(0);
    shadow[32'h30] = 32'h12345678;
    @(negedge clk);
    reset_n = 1'b1;
    last_g = 1; exp_rd[0] = '0; exp_rd[1] = '0;
    chk("abort_strobe_low", 64'(if0_strobe), 64'(0));
    chk("abort_busy", 64'(arb_busy), 64'(0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_ack", 64'(r0_ack | r1_ack), 64'(0));
    end
    chk("abort_r0_rddata", 64'(r0_rddata), 64'(0));
    set_req(0, AW'(32'h0030), '0, 4'h0, 1'b0);
    set_req(1, AW'(32'h0010), '0, 4'h0, 1'b0);
    e = exp_winner(1, 1, cfg_r0_prio);
    wait_ack(who, cyc);
    chk("tie_after_rst", 64'(who), 64'(e));
    if (who >= 0) begin
      on_ack(who);
      drop_req(who);
      wait_ack(who, cyc);
      if (who >= 0) on_ack(who);
    end
    drop_req(0); drop_req(1);
    repeat (2) @(negedge clk);

    // r0 presents a new request in the ack cycle: exactly one more grant.
    set_req(0, AW'(32'h0010), '0, 4'h0, 1'b0);
    wait_ack(who, cyc);
    chk("rereq_first", 64'(who), 64'(0));
    if (who == 0) on_ack(0);
    set_req(0, AW'(32'h0040), 32'hA5A55A5A, 4'hF, 1'b1);
    chk("rereq_busy_done", 64'(arb_busy), 64'(1));
    @(negedge clk);
    chk("rereq_busy_idle", 64'(arb_busy), 64'(0));
    wait_ack(who, cyc);
    chk("rereq_second", 64'(who), 64'(0));
    if (who == 0) on_ack(0);
    drop_req(0);
    m = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (r0_ack === 1'b1 || r1_ack === 1'b1) m++;
    end
    chk("rereq_no_dup", 64'(m), 64'(0));
    chk("rereq_ram", 64'(vmem[32'h40]), 64'(32'hA5A55A5A));

    // Randomized traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      cfg_r0_prio = 1'($urandom_range(0, 1));
      m = int'($urandom_range(1, 3));
      p0 = m[0]; p1 = m[1]; pair = p0 && p1;
      for (int n = 0; n < 2; n++)
        if (m[n]) set_req(n, AW'(32'h20 + $urandom_range(0, 7)), $urandom,
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      while (p0 || p1) begin
        e = exp_winner(p0, p1, cfg_r0_prio);
        wait_ack(who, cyc);
        chk("rnd_winner", 64'(who), 64'(e));
        if (who < 0) break;
        if (!pair) chk("rnd_latency_ok", 64'(cyc >= 3 && cyc <= 6), 64'(1));
        on_ack(who);
        drop_req(who);
        if (who == 0) p0 = 0; else p1 = 0;
        pair = 0;
        if (p0 || p1) cyc = 0;
      end
      drop_req(0); drop_req(1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_if0_arb.md
VRAM_IF0_ARB -- requirements
Module: vram_if0_arb

Interface
REQ-001 Parameter ADDR_W, default 15, meaning word address width of VRAM interface 0.
REQ-002 Parameter DATA_W, default 32, meaning data width of VRAM interface 0.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 cfg_r0_prio  in  1  1 = fixed priority to requester 0; 0 = round-robin.
REQ-006 rN_req  in  1  (N=0,1) access request, held until rN_ack.
REQ-007 rN_addr  in  ADDR_W  (N=0,1) word address, stable while rN_req high.
REQ-008 rN_wrdata  in  DATA_W  (N=0,1) write data.
REQ-009 rN_wrbytesel  in  4  (N=0,1) byte enables for writes.
REQ-010 rN_write  in  1  (N=0,1) 1 = write, 0 = read.
REQ-011 rN_ack  out  1  (N=0,1) one-cycle completion pulse.
REQ-012 rN_rddata  out  DATA_W  (N=0,1) read data, valid with rN_ack and held until the next rN_ack.
REQ-013 if0_addr, if0_wrdata, if0_wrbytesel, if0_write  out  ADDR_W/DATA_W/4/1  registered copies of the winner's request.
REQ-014 if0_strobe  out  1  request to the VRAM port; held high until if0_ack.
REQ-015 if0_ack  in  1  VRAM completion, arrives in the cycle after the port's slot.
REQ-016 if0_rddata  in  DATA_W  VRAM read data, valid when if0_ack is high.
REQ-017 arb_busy  out  1  high in any state other than IDLE.

Function
REQ-018 State machine states: IDLE, WAIT, DONE; all outputs registered.
REQ-019 IDLE, no request: remain IDLE, if0_strobe=0.
REQ-020 IDLE, any request: latch the winner's addr, wrdata, wrbytesel and write into the if0_* registers; set if0_strobe=1; record winner; go to WAIT.
REQ-021 Winner, one request: that requester.
REQ-022 Winner, both requesting, cfg_r0_prio=1: requester 0.
REQ-023 Winner, both requesting, cfg_r0_prio=0: the requester not recorded as last_grant; last_grant updates on every grant.
REQ-024 WAIT, if0_ack=0: hold if0_strobe and all if0_* fields unchanged, with no timeout.
REQ-025 WAIT, if0_ack=1: capture if0_rddata into the winner's rN_rddata (reads only; writes leave rN_rddata unchanged); clear if0_strobe; assert the winner's rN_ack; go to DONE.
REQ-026 DONE lasts exactly one cycle, then goes to IDLE.
REQ-027 Requests are not sampled in DONE, so a requester may present a new request in the cycle after its ack without a duplicate grant.
REQ-028 if0_ack outside WAIT is ignored; no ack pulse and no data capture.
REQ-029 Latency from IDLE sampling rN_req to rN_ack is 3 cycles minimum and 6 cycles maximum with the 4-slot VRAM rotation.
REQ-030 At most one rN_ack is high in any cycle.
REQ-031 cfg_r0_prio changes take effect at the next IDLE arbitration only.
REQ-032 Requester-side changes to rN_* fields during WAIT do not alter the if0_* fields.

Reset
REQ-033 reset_n=0 at a clock edge forces: state=IDLE, if0_strobe=0, if0_addr/wrdata/wrbytesel/write=0, r0_ack=r1_ack=0, r0_rddata=r1_rddata=0, last_grant=1 (so requester 0 wins the first tie).
REQ-034 Reset during WAIT abandons the access; a VRAM write already committed stays committed, and the late if0_ack is ignored per REQ-028.

Structure
REQ-035 State encodings (IDLE/WAIT/DONE) and the ADDR_W/DATA_W defaults live in the shared VERA package.
REQ-036 Single flat module; the winner select is a small combinational function, with no sub-module.

Verification
REQ-037 Bench uses a vram_if behavioural model: 4-slot rotation, ack one cycle after slot 0, write committed in the slot cycle.
REQ-038 r0 write, addr=0x0010, data=0xDEADBEEF, bytesel=0xF -> if0_write=1 held until if0_ack; r0_ack single pulse 3-6 cycles after req; model RAM[0x0010]=0xDEADBEEF.
REQ-039 r1 read of 0x0010 after REQ-038 -> r1_ack pulse; r1_rddata=0xDEADBEEF and held after req drops.
REQ-040 Both requesting continuously, cfg_r0_prio=0, 6 accesses -> grant order r0,r1,r0,r1,r0,r1.
REQ-041 Same stimulus as REQ-040 with cfg_r0_prio=1 -> r0 granted all 6 times while held; r1 granted only after r0_req drops.
REQ-042 reset_n=0 in the cycle after strobe rises -> strobe 0 next cycle; the subsequent if0_ack produces no rN_ack; the first tie after reset goes to r0.
REQ-043 r0 re-requests in the cycle right after r0_ack -> exactly one new grant, no duplicate ack; arb_busy low in IDLE only.
